// File: rtl/reg_bank_ctrl.sv
// Requester-side controller for the 4-entry register bank.
// Buffers writebacks, serialises bank writes and operand reads.
module reg_bank_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int WB_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_src_1,
  input  logic [ADDR_W-1:0] rd_src_2,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_data_1,
  output logic [DATA_W-1:0] rd_rsp_data_2,
  output logic              opwrite,
  output logic [ADDR_W-1:0] reg_write,
  output logic [ADDR_W-1:0] src_1,
  output logic [ADDR_W-1:0] src_2,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] data_src_1,
  input  logic [DATA_W-1:0] data_src_2
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL =
    (PTR_W+1)'(WB_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE =
    (PTR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] fifo_reg [WB_DEPTH];
  logic [DATA_W-1:0] fifo_dat [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop;

  logic              opw_d, vld_d;
  logic [ADDR_W-1:0] reg_d, s1_d, s2_d;
  logic [DATA_W-1:0] dat_d, r1_d, r2_d;

  assign full   = count == CNT_FULL;
  assign empty  = count == '0;
  assign push   = wb_valid & ~full;
  assign pop    = state == WRITE;
  assign rd_nxt = rd_ptr + PTR_W'(1);

  assign wb_ready = ~full;
  // A writeback offered in the same cycle wins, so the read sees it.
  assign rd_req_ready = (state == IDLE) & empty & ~wb_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        fifo_reg[i] <= '0;
        fifo_dat[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_reg[wr_ptr] <= wb_reg;
        fifo_dat[wr_ptr] <= wb_data;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    opw_d   = 1'b0;
    reg_d   = reg_write;
    dat_d   = data;
    s1_d    = src_1;
    s2_d    = src_2;
    vld_d   = rd_rsp_valid;
    r1_d    = rd_rsp_data_1;
    r2_d    = rd_rsp_data_2;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_d = WRITE;
          opw_d   = 1'b1;
          reg_d   = fifo_reg[rd_ptr];
          dat_d   = fifo_dat[rd_ptr];
        end else if (rd_req_valid && rd_req_ready) begin
          state_d = RD_ISSUE;
          s1_d    = rd_src_1;
          s2_d    = rd_src_2;
        end
      end
      WRITE: begin
        // Next head is either queued or arriving on this very edge.
        if (count > CNT_ONE) begin
          opw_d = 1'b1;
          reg_d = fifo_reg[rd_nxt];
          dat_d = fifo_dat[rd_nxt];
        end else if (push) begin
          opw_d = 1'b1;
          reg_d = wb_reg;
          dat_d = wb_data;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = RESP;
        vld_d   = 1'b1;
        r1_d    = data_src_1;
        r2_d    = data_src_2;
      end
      RESP: begin
        if (rd_rsp_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      opwrite       <= 1'b0;
      reg_write     <= '0;
      data          <= '0;
      src_1         <= '0;
      src_2         <= '0;
      rd_rsp_valid  <= 1'b0;
      rd_rsp_data_1 <= '0;
      rd_rsp_data_2 <= '0;
    end else begin
      state         <= state_d;
      opwrite       <= opw_d;
      reg_write     <= reg_d;
      data          <= dat_d;
      src_1         <= s1_d;
      src_2         <= s2_d;
      rd_rsp_valid  <= vld_d;
      rd_rsp_data_1 <= r1_d;
      rd_rsp_data_2 <= r2_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: behavioural bank, write log and
// scoreboard queues for expected writes and read responses.
module tb_reg_bank_ctrl;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_src_1 = '0;
  logic [AW-1:0] rd_src_2 = '0;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready = 1'b0;
  logic [DW-1:0] rd_rsp_data_1;
  logic [DW-1:0] rd_rsp_data_2;
  logic          opwrite;
  logic [AW-1:0] reg_write;
  logic [AW-1:0] src_1;
  logic [AW-1:0] src_2;
  logic [DW-1:0] data;
  logic [DW-1:0] data_src_1;
  logic [DW-1:0] data_src_2;

  reg_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_src_1(rd_src_1), .rd_src_2(rd_src_2),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data_1(rd_rsp_data_1), .rd_rsp_data_2(rd_rsp_data_2),
    .opwrite(opwrite), .reg_write(reg_write),
    .src_1(src_1), .src_2(src_2), .data(data),
    .data_src_1(data_src_1), .data_src_2(data_src_2)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] bank [4];
  logic [AW-1:0] wl_reg [64];
  logic [DW-1:0] wl_dat [64];
  int            wl_cyc [64];
  int            wcnt = 0;
  int            cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK or negedge RST_N)
    if (!RST_N) for (int i = 0; i < 4; i++) bank[i] <= '0;
    else if (opwrite) bank[reg_write] <= data;

  always @(posedge CLK) begin
    data_src_1 <= bank[src_1];
    data_src_2 <= bank[src_2];
  end

  always @(negedge CLK)
    if (RST_N && opwrite) begin
      wl_reg[wcnt[5:0]] <= reg_write;
      wl_dat[wcnt[5:0]] <= data;
      wl_cyc[wcnt[5:0]] <= cyc;
      wcnt <= wcnt + 1;
    end

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wexp_t;

  wexp_t         exp_wq [$];
  logic [63:0]   exp_rq [$];
  logic [DW-1:0] mdl [4];
  int            tests = 0;
  int            fails = 0;
  int            widx = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] r,
                      input logic [DW-1:0] d);
    int n = 0;
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    #1;
    while (!wb_ready && n < 50) begin tick(); n++; end
    chk("push_tmo", 64'(n < 50), 1);
    if (wb_ready) begin
      exp_wq.push_back('{r, d});
      mdl[r] = d;
    end
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic read_issue(input logic [AW-1:0] s1,
                            input logic [AW-1:0] s2);
    int n = 0;
    rd_req_valid = 1'b1;
    rd_src_1 = s1;
    rd_src_2 = s2;
    #1;
    while (!rd_req_ready && n < 50) begin tick(); n++; end
    chk("rd_acc_tmo", 64'(n < 50), 1);
    exp_rq.push_back({mdl[s1], mdl[s2]});
    tick();
    rd_req_valid = 1'b0;
    chk("src_1", 64'(src_1), 64'(s1));
    chk("src_2", 64'(src_2), 64'(s2));
    tick();
    chk("rsp_early", 64'(rd_rsp_valid), 0);
    tick();
    chk("rsp_lat", 64'(rd_rsp_valid), 1);
  endtask

  task automatic rsp_take();
    logic [63:0] e;
    e = exp_rq.pop_front();
    rd_rsp_ready = 1'b1;
    chk("rsp_d1", 64'(rd_rsp_data_1), 64'(e[63:32]));
    chk("rsp_d2", 64'(rd_rsp_data_2), 64'(e[31:0]));
    tick();
    rd_rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rd_rsp_valid), 0);
  endtask

  task automatic check_writes();
    wexp_t e;
    int n;
    while (exp_wq.size() > 0) begin
      e = exp_wq.pop_front();
      n = 0;
      while (wcnt <= widx && n < 50) begin tick(); n++; end
      chk("wr_tmo", 64'(n < 50), 1);
      chk("wr_reg", 64'(wl_reg[widx[5:0]]), 64'(e.r));
      chk("wr_dat", 64'(wl_dat[widx[5:0]]), 64'(e.d));
      widx++;
    end
  endtask

  task automatic chk_b2b(input string tag);
    chk(tag, 64'(wl_cyc[widx-1] - wl_cyc[widx-2]), 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    tick();
    tick();
    chk("rst_opw", 64'(opwrite), 0);
    chk("rst_wbr", 64'(wb_ready), 1);
    chk("rst_rdr", 64'(rd_req_ready), 1);
    chk("rst_vld", 64'(rd_rsp_valid), 0);
    chk("rst_d1", 64'(rd_rsp_data_1), 0);
    chk("rst_dat", 64'(data), 0);
    RST_N = 1'b1;
    tick();

    push(2'd0, 32'd256);
    push(2'd1, 32'h0000_0011);
    check_writes();
    chk_b2b("wr_b2b_1");
    read_issue(2'd0, 2'd1);
    rsp_take();
    chk("wcnt_1", 64'(wcnt), 64'(widx));

    wb_valid = 1'b1;
    wb_reg = 2'd1;
    wb_data = 32'hDEAD_BEEF;
    rd_req_valid = 1'b1;
    rd_src_1 = 2'd1;
    rd_src_2 = 2'd0;
    #1;
    chk("ord_rdr", 64'(rd_req_ready), 0);
    exp_wq.push_back('{2'd1, 32'hDEAD_BEEF});
    mdl[1] = 32'hDEAD_BEEF;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("ord_rdr2", 64'(rd_req_ready), 0);
    read_issue(2'd1, 2'd0);
    rsp_take();
    check_writes();

    read_issue(2'd2, 2'd3);
    rd_req_valid = 1'b1;
    rd_src_1 = 2'd0;
    rd_src_2 = 2'd0;
    wb_valid = 1'b1;
    wb_reg = 2'd2;
    wb_data = 32'hA5A5_0002;
    #1;
    chk("full_r0", 64'(wb_ready), 1);
    exp_wq.push_back('{2'd2, 32'hA5A5_0002});
    mdl[2] = 32'hA5A5_0002;
    tick();
    wb_reg = 2'd3;
    wb_data = 32'h5A5A_0003;
    chk("full_r1", 64'(wb_ready), 1);
    exp_wq.push_back('{2'd3, 32'h5A5A_0003});
    mdl[3] = 32'h5A5A_0003;
    tick();
    wb_reg = 2'd0;
    wb_data = 32'hCCCC_0000;
    chk("full_r2", 64'(wb_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vld", 64'(rd_rsp_valid), 1);
      chk("bp_d1", 64'(rd_rsp_data_1), 64'(exp_rq[0][63:32]));
      chk("bp_d2", 64'(rd_rsp_data_2), 64'(exp_rq[0][31:0]));
      chk("bp_rdr", 64'(rd_req_ready), 0);
      chk("bp_opw", 64'(opwrite), 0);
      chk("bp_wbr", 64'(wb_ready), 0);
    end
    wb_valid = 1'b0;
    rd_req_valid = 1'b0;
    chk("bp_wcnt", 64'(wcnt), 64'(widx));
    rsp_take();
    check_writes();
    chk_b2b("wr_b2b_full");
    read_issue(2'd2, 2'd3);
    rsp_take();
    read_issue(2'd0, 2'd3);
    rsp_take();

    push(2'd1, 32'h0000_5555);
    tick();
    chk("pp_opw0", 64'(opwrite), 1);
    wb_valid = 1'b1;
    wb_reg = 2'd0;
    wb_data = 32'h0000_0077;
    chk("pp_wbr0", 64'(wb_ready), 1);
    exp_wq.push_back('{2'd0, 32'h0000_0077});
    mdl[0] = 32'h0000_0077;
    tick();
    wb_valid = 1'b0;
    chk("pp_opw1", 64'(opwrite), 1);
    chk("pp_reg", 64'(reg_write), 0);
    chk("pp_dat", 64'(data), 64'h77);
    chk("pp_wbr1", 64'(wb_ready), 1);
    tick();
    chk("pp_opw2", 64'(opwrite), 0);
    check_writes();
    chk_b2b("wr_b2b_pp");

    wb_valid = 1'b1;
    wb_reg = 2'd2;
    wb_data = 32'h0000_0099;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("rw_opw", 64'(opwrite), 1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("ar_opw", 64'(opwrite), 0);
    chk("ar_wbr", 64'(wb_ready), 1);
    chk("ar_rdr", 64'(rd_req_ready), 1);
    chk("ar_vld", 64'(rd_rsp_valid), 0);
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    tick();
    RST_N = 1'b1;
    tick();
    chk("ar_wcnt", 64'(wcnt), 64'(widx));
    read_issue(2'd1, 2'd2);
    rsp_take();
    chk("end_wcnt", 64'(wcnt), 64'(widx));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
